// File: rtl/router_input_unit.sv
// rtl/router_input_unit.sv - torus router input stage: flit register, DOR route compute, FWFT FIFO
//
// Purpose: registers flits arriving from one MGT receive link, computes the
// dimension-order (X, then Y, then Z) shortest-path output port against this
// node's coordinates, and queues {route, flit} in a first-word-fall-through
// FIFO for the switch allocator. The link cannot be stalled, so pushes into a
// full FIFO are dropped, counted and flagged.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_flit      flit from the MGT receiver
//   in_valid     in_flit qualifier, at most one flit per cycle
//   out_flit     head-of-FIFO flit (0 while empty)
//   out_port     head route: 0 xpos, 1 ypos, 2 zpos, 3 xneg, 4 yneg, 5 zneg, 6 eject
//   out_valid    FIFO non-empty
//   out_ready    crossbar accepts the head this cycle
//   almost_full  occupancy >= DEPTH-2
//   overflow     sticky, a flit has been dropped since reset
//   drop_count   saturating count of dropped flits
module router_input_unit #(
  parameter int cur_x     = 0,
  parameter int cur_y     = 0,
  parameter int cur_z     = 0,
  parameter int X_SIZE    = 4,
  parameter int Y_SIZE    = 4,
  parameter int Z_SIZE    = 4,
  parameter int COORD_W   = 4,
  parameter int FLIT_SIZE = 256,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] in_flit,
  input  logic                 in_valid,
  output logic [FLIT_SIZE-1:0] out_flit,
  output logic [2:0]           out_port,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 almost_full,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = FLIT_SIZE + 3;
  localparam int DW      = COORD_W + 1;

  localparam logic [DW-1:0] CUR_X  = DW'(cur_x);
  localparam logic [DW-1:0] CUR_Y  = DW'(cur_y);
  localparam logic [DW-1:0] CUR_Z  = DW'(cur_z);
  localparam logic [DW-1:0] SIZE_X = DW'(X_SIZE);
  localparam logic [DW-1:0] SIZE_Y = DW'(Y_SIZE);
  localparam logic [DW-1:0] SIZE_Z = DW'(Z_SIZE);
  localparam logic [DW-1:0] HALF_X = DW'(X_SIZE / 2);
  localparam logic [DW-1:0] HALF_Y = DW'(Y_SIZE / 2);
  localparam logic [DW-1:0] HALF_Z = DW'(Z_SIZE / 2);

  // Forward distance around the ring, one extra bit so a negative raw
  // difference shows up in the MSB and can be folded back by adding the size.
  function automatic logic [DW-1:0] ring_delta(input logic [COORD_W-1:0] dst,
                                               input logic [DW-1:0] cur,
                                               input logic [DW-1:0] size);
    logic [DW-1:0] d;
    d = {1'b0, dst} - cur;
    if (d[DW-1]) d = d + size;
    return d;
  endfunction

  logic [COORD_W-1:0] dst_x, dst_y, dst_z;
  logic [DW-1:0]      dx, dy, dz;
  logic [2:0]         in_route;

  assign dst_x = in_flit[FLIT_SIZE-1 -: COORD_W];
  assign dst_y = in_flit[FLIT_SIZE-1-COORD_W -: COORD_W];
  assign dst_z = in_flit[FLIT_SIZE-1-2*COORD_W -: COORD_W];
  assign dx    = ring_delta(dst_x, CUR_X, SIZE_X);
  assign dy    = ring_delta(dst_y, CUR_Y, SIZE_Y);
  assign dz    = ring_delta(dst_z, CUR_Z, SIZE_Z);

  // First unresolved dimension wins; an exact half-ring distance goes positive.
  always_comb begin
    in_route = 3'd6;
    if (dx != '0)      in_route = (dx <= HALF_X) ? 3'd0 : 3'd3;
    else if (dy != '0) in_route = (dy <= HALF_Y) ? 3'd1 : 3'd4;
    else if (dz != '0) in_route = (dz <= HALF_Z) ? 3'd2 : 3'd5;
  end

  logic                 s1_valid_q, s1_valid_d;
  logic [FLIT_SIZE-1:0] s1_flit_q, s1_flit_d;
  logic [2:0]           s1_port_q, s1_port_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_count_q, drop_count_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   head;
  logic                 full, pop, wr_en, drop;

  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= CNT_W'(DEPTH - 2));
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;
  assign head        = mem_q[rd_ptr_q];
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign out_flit    = out_valid ? head[FLIT_SIZE-1:0] : '0;
  assign out_port    = out_valid ? head[ENTRY_W-1 -: 3] : 3'd0;

  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    pop   = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en = s1_valid_q && (!full || pop);
    drop  = s1_valid_q && full && !pop;

    s1_valid_d   = in_valid;
    s1_flit_d    = in_valid ? in_flit : s1_flit_q;
    s1_port_d    = in_valid ? in_route : s1_port_q;
    wr_ptr_d     = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
    overflow_d   = overflow_q || drop;
    drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_flit_q    <= '0;
      s1_port_q    <= 3'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_flit_q    <= s1_flit_d;
      s1_port_q    <= s1_port_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s1_port_q, s1_flit_q};
  end

endmodule
